mux_4_1_rr_arbiter: RTL and testbench
=====================================

// Module: mux_4_1_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one 8-bit output channel between 4 requesters.
//   Sequences the 4:1 8-bit mux: drives its select and enable from a registered grant.
//   Bounds each grant with a hold limit and hands over without idle cycles when others wait.
//   Sits between the 4 code producers and the single downstream consumer of o_code.
// PARAMETERS
//   MAX_HOLD  4  max consecutive grant cycles while another requester waits (>=1)
//   DATA_W    8  width of each code bus and o_code
// PORTS
//   i_clk       in   1       clock; all state updates on rising edge
//   i_rst_n     in   1       reset, synchronous, active-low
//   i_en        in   1       arbiter enable; low forces IDLE on next edge
//   i_req       in   4       request per requester, level-sensitive, bit n = requester n
//   i_code_0..3 in   DATA_W  code from requester 0..3
//   o_grant     out  4       one-hot registered grant, 0 when idle
//   o_sel_code  out  2       registered index of current owner (mux select)
//   o_valid     out  1       registered; 1 while a grant is held (mux enable)
//   o_code      out  DATA_W  o_valid ? i_code_<o_sel_code> : 0 (combinational from regs)
// BEHAVIOUR
//   Reset (i_rst_n=0 at edge): o_grant=0, o_sel_code=2'b00, o_valid=0 (so o_code=0),
//     state=IDLE, hold_cnt=0, ptr=3 so requester 0 has top priority first. Reset mid-grant
//     drops the grant on that edge.
//   Priority: rotating; search order ptr+1, ptr+2, ptr+3, ptr (mod 4). ptr <= winner on each new grant.
//   States: IDLE, GRANT.
//   IDLE: if i_en & |i_req -> GRANT to winner, o_grant/o_sel_code/o_valid set on next edge
//     (request-to-grant latency 1 cycle), hold_cnt <= 1. Else stay IDLE.
//   GRANT (owner k), evaluated each edge, first match wins:
//     - i_en=0 -> IDLE, outputs cleared, ptr kept.
//     - i_req[k]=0 -> if other requests: GRANT to new winner (no bubble), hold_cnt<=1;
//       else IDLE.
//     - hold_cnt==MAX_HOLD and another request pending -> forced handover to winner
//       among others (k is searched last), hold_cnt<=1.
//     - else keep k; hold_cnt <= hold_cnt+1 saturating at MAX_HOLD.
//   Sole requester keeps grant indefinitely (counter saturates, no forced release).
//   Released owner re-asserting is a fresh request; rotation puts it behind the others.
//   Requests arriving the same cycle as a release are considered in that arbitration.
//   hold_cnt width: $clog2(MAX_HOLD+1); no wrap.
//   o_grant always one-hot or zero; o_grant==(1<<o_sel_code) whenever o_valid=1.
// STRUCTURE
//   Shared include file: state encodings (ST_IDLE, ST_GRANT), NUM_REQ=4, SEL_W=2.
//   Sub-module rr_pick_4 (combinational): inputs req[3:0], ptr[1:0], mask_idx,
//     use_mask; outputs any, idx[1:0] of rotating-priority winner.
//   Datapath: instantiate the team's 4:1 8-bit mux with sel=o_sel_code, en=o_valid.
//   Single always block for state, ptr, hold_cnt and registered outputs.
// TESTING
//   1 Reset held 3 cycles with i_req=4'b1111, i_en=1 -> all outputs 0; first edge after
//     release grants 0 (o_grant=0001), o_code=i_code_0 one cycle later... i.e. at that edge.
//   2 i_req=1111 constant, MAX_HOLD=4 -> grant 0,1,2,3,0 each exactly 4 cycles, no idle
//     cycle; o_code tracks i_code_<owner> (codes 8'hA0..8'hA3).
//   3 Only i_req[2] high for 10 cycles -> o_grant=0100 all 10 cycles, o_valid never drops.
//   4 Owner 1 drops req at cycle 2 with i_req[3]=1 -> next edge o_grant=1000,
//     o_code=i_code_3 (8'h5C); ptr=3.
//   5 i_en low mid-grant of owner 2 -> next edge o_valid=0, o_code=8'h00; i_en high again
//     with i_req=1111 -> next grant to 3 (ptr=2 retained).
//   6 i_rst_n low during grant of owner 1 -> next edge outputs 0, after release grant to 0.

Source files
------------

// File: rtl/mux_4_1_rr_arbiter_pkg.sv
// Shared constants and types for the 4-requester round-robin arbiter.
// State encodings stay plain localparams so legacy code can compare against them.
package mux_4_1_rr_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  typedef logic [NUM_REQ-1:0] req_t;
  typedef logic [SEL_W-1:0]   sel_t;

endpackage

// File: rtl/mux_4_1_8.sv
// 4:1 code mux with enable; output is zero when disabled.
module mux_4_1_8 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  input  logic [DATA_W-1:0] d2_i,
  input  logic [DATA_W-1:0] d3_i,
  input  logic [1:0]        sel_i,
  input  logic              en_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) begin
      unique case (sel_i)
        2'd0:    y_o = d0_i;
        2'd1:    y_o = d1_i;
        2'd2:    y_o = d2_i;
        default: y_o = d3_i;
      endcase
    end
  end

endmodule

// File: rtl/rr_pick_4.sv
// Rotating-priority picker: searches ptr+1, ptr+2, ptr+3, ptr (mod 4).
// With use_mask_i set, requester mask_idx_i is excluded from the search.
module rr_pick_4
  import mux_4_1_rr_arbiter_pkg::*;
(
  input  req_t req_i,
  input  sel_t ptr_i,
  input  sel_t mask_idx_i,
  input  logic use_mask_i,
  output logic any_o,
  output sel_t idx_o
);

  req_t eff_req;
  sel_t cand;
  logic found;

  always_comb begin
    eff_req = req_i;
    if (use_mask_i) begin
      eff_req[mask_idx_i] = 1'b0;
    end
    any_o = |eff_req;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    // Offset NUM_REQ wraps to ptr itself, so the last owner is searched last.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ptr_i + sel_t'(i);
      if (!found && eff_req[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter sharing one code channel between 4 requesters, with a
// bounded hold time and bubble-free handover when others are waiting.
module mux_4_1_rr_arbiter
  import mux_4_1_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [3:0]        i_req,
  input  logic [DATA_W-1:0] i_code_0,
  input  logic [DATA_W-1:0] i_code_1,
  input  logic [DATA_W-1:0] i_code_2,
  input  logic [DATA_W-1:0] i_code_3,
  output logic [3:0]        o_grant,
  output logic [1:0]        o_sel_code,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_code
);

  localparam int unsigned     HoldW   = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  logic [0:0]       state_q, state_d;
  sel_t             ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  req_t             grant_q, grant_d;
  sel_t             sel_q, sel_d;
  logic             valid_q, valid_d;

  logic pick_any;
  sel_t pick_idx;
  logic take, drop;

  // While granted, the owner is masked so pick_any means "someone else waits".
  rr_pick_4 u_pick (
    .req_i      (i_req),
    .ptr_i      (ptr_q),
    .mask_idx_i (sel_q),
    .use_mask_i (valid_q),
    .any_o      (pick_any),
    .idx_o      (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    take    = 1'b0;
    drop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_en && pick_any) take = 1'b1;
      end
      default: begin
        if (!i_en) begin
          drop = 1'b1;
        end else if (!i_req[sel_q]) begin
          if (pick_any) take = 1'b1;
          else          drop = 1'b1;
        end else if (hold_q == HoldMax && pick_any) begin
          take = 1'b1;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + HoldW'(1);
        end
      end
    endcase

    if (take) begin
      state_d = ST_GRANT;
      ptr_d   = pick_idx;
      sel_d   = pick_idx;
      grant_d = req_t'(1) << pick_idx;
      valid_d = 1'b1;
      hold_d  = HoldW'(1);
    end
    if (drop) begin
      state_d = ST_IDLE;
      sel_d   = '0;
      grant_d = '0;
      valid_d = 1'b0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= sel_t'(NUM_REQ - 1);
      hold_q  <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_sel_code = sel_q;
  assign o_valid    = valid_q;

  mux_4_1_8 #(
    .DATA_W (DATA_W)
  ) u_mux (
    .d0_i  (i_code_0),
    .d1_i  (i_code_1),
    .d2_i  (i_code_2),
    .d3_i  (i_code_3),
    .sel_i (o_sel_code),
    .en_i  (o_valid),
    .y_o   (o_code)
  );

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Bench for mux_4_1_rr_arbiter: behavioural model feeds a scoreboard queue,
// plus directed checks of the listed scenarios.
module tb_mux_4_1_rr_arbiter;

  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic [7:0] code;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [7:0] codes [4];
  logic [3:0] o_grant;
  logic [1:0] o_sel_code;
  logic       o_valid;
  logic [7:0] o_code;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  int m_owner = -1;
  int m_ptr   = 3;
  int m_hold  = 0;

  always #5 clk = ~clk;

  mux_4_1_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .DATA_W   (8)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_req      (req),
    .i_code_0   (codes[0]),
    .i_code_1   (codes[1]),
    .i_code_2   (codes[2]),
    .i_code_3   (codes[3]),
    .o_grant    (o_grant),
    .o_sel_code (o_sel_code),
    .o_valid    (o_valid),
    .o_code     (o_code)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int model_pick(input logic [3:0] r, input int ptr, input int excl);
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (ptr + i) % 4;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  // Advance the reference model by one clock edge using the driven inputs.
  task automatic model_step(input logic r_n, input logic e, input logic [3:0] r);
    int w;
    if (!r_n) begin
      m_owner = -1; m_ptr = 3; m_hold = 0;
    end else if (m_owner < 0) begin
      w = model_pick(r, m_ptr, -1);
      if (e && w >= 0) begin
        m_owner = w; m_ptr = w; m_hold = 1;
      end
    end else if (!e) begin
      m_owner = -1; m_hold = 0;
    end else begin
      w = model_pick(r, m_ptr, m_owner);
      if (!r[m_owner] || (m_hold == MAX_HOLD && w >= 0)) begin
        if (w >= 0) begin
          m_owner = w; m_ptr = w; m_hold = 1;
        end else begin
          m_owner = -1; m_hold = 0;
        end
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
    end
  endtask

  task automatic cyc(input logic r_n, input logic e, input logic [3:0] r);
    exp_t x;
    @(negedge clk);
    rst_n = r_n; en = e; req = r;
    model_step(r_n, e, r);
    x.valid = (m_owner >= 0);
    x.grant = x.valid ? 4'(1 << m_owner) : 4'h0;
    x.sel   = x.valid ? 2'(m_owner) : 2'd0;
    x.code  = x.valid ? codes[m_owner] : 8'h00;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_eq("grant", 32'(o_grant), 32'(x.grant));
    check_eq("sel",   32'(o_sel_code), 32'(x.sel));
    check_eq("valid", 32'(o_valid), 32'(x.valid));
    check_eq("code",  32'(o_code), 32'(x.code));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req = 4'b1111;
    for (int i = 0; i < 4; i++) codes[i] = 8'hA0 + 8'(i);

    // Reset held with all requests pending, then release.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b1111);
    check_eq("t1_rst_valid", 32'(o_valid), 32'd0);
    check_eq("t1_rst_code", 32'(o_code), 32'd0);
    cyc(1'b1, 1'b1, 4'b1111);
    check_eq("t1_first_grant", 32'(o_grant), 32'h1);
    check_eq("t1_first_code", 32'(o_code), 32'hA0);

    // Full contention: each owner holds exactly MAX_HOLD cycles.
    for (int i = 0; i < 19; i++) begin
      cyc(1'b1, 1'b1, 4'b1111);
      check_eq("t2_rotation", 32'(o_grant), 32'(1 << (((i + 1) / MAX_HOLD) % 4)));
    end

    // Sole requester keeps the grant indefinitely.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 4'b0100);
      check_eq("t3_sole", 32'(o_grant), 32'h4);
    end

    // Owner 1 drops while 3 waits.
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b1, 1'b1, 4'b0010);
    cyc(1'b1, 1'b1, 4'b0010);
    codes[3] = 8'h5C;
    cyc(1'b1, 1'b1, 4'b1000);
    check_eq("t4_grant", 32'(o_grant), 32'h8);
    check_eq("t4_code", 32'(o_code), 32'h5C);

    // Enable low mid-grant of owner 2, then contention resumes after ptr=2.
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b1, 1'b1, 4'b0100);
    cyc(1'b1, 1'b1, 4'b0100);
    cyc(1'b1, 1'b0, 4'b0100);
    check_eq("t5_valid", 32'(o_valid), 32'd0);
    check_eq("t5_code", 32'(o_code), 32'd0);
    cyc(1'b1, 1'b1, 4'b1111);
    check_eq("t5_next", 32'(o_grant), 32'h8);

    // Reset mid-grant of owner 1.
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b1, 1'b1, 4'b0010);
    cyc(1'b1, 1'b1, 4'b0010);
    cyc(1'b0, 1'b1, 4'b0010);
    check_eq("t6_rst_grant", 32'(o_grant), 32'd0);
    cyc(1'b1, 1'b1, 4'b1111);
    check_eq("t6_after", 32'(o_grant), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) begin
        for (int k = 0; k < 4; k++) codes[k] = 8'($urandom);
      end
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
          4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
